request_arbiter: RTL and testbench

REQUEST_ARBITER -- requirements
Module: request_arbiter

---
 rtl/request_arbiter_if.sv | 26 ++
 rtl/request_arbiter.sv | 129 ++++++++++++
 tb/tb_request_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/request_arbiter_if.sv
// Handshake bundle between request_arbiter (master) and the requesters/encoder side (slave).
interface request_arbiter_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         grant_ready;
  logic [7:0]   grant_cnt;

  modport master (
    input  req,
    input  grant_ready,
    output grant,
    output grant_valid,
    output grant_cnt
  );

  modport slave (
    output req,
    output grant_ready,
    input  grant,
    input  grant_valid,
    input  grant_cnt
  );
endinterface

// File: rtl/request_arbiter.sv
// One-hot request arbiter with a two-state IDLE/OFFER handshake and a wrapping handshake counter.
// Define REQUEST_ARBITER_ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index priority.
module request_arbiter #(
  parameter int unsigned N = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  request_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state;
  logic [N-1:0]     grant_q;
  logic             valid_q;
  logic [7:0]       cnt_q;
  logic [IDX_W-1:0] ptr;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;

  // Scan upward from ptr; index arithmetic wraps naturally because N is a power of two.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = win_found;
  end

`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] ptr_q;

  assign ptr = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_onehot;
            valid_q <= 1'b1;
            win_q   <= win_idx;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (bus.grant_ready) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
            ptr_q   <= win_q + IDX_W'(1);
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign ptr = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_onehot;
            valid_q <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (bus.grant_ready) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_cnt   = cnt_q;

endmodule

// File: tb/tb_request_arbiter.sv
// Scoreboard bench for request_arbiter: expected grants are queued with the stimulus and popped on each handshake.
module tb_request_arbiter;

  localparam int unsigned N = 16;
`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  request_arbiter_if #(.N(N)) bus ();

  request_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [N-1:0] exp_q[$];
  bit           mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g, input logic v, input logic [7:0] c);
    check_eq({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check_eq({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    check_eq({tag, ".cnt"}, 32'(bus.grant_cnt), 32'(c));
  endtask

  function automatic logic [3:0] enc(input logic [N-1:0] g);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction

  // Inputs change #1 after posedge, so the negedge sample matches what the next posedge sees.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      if (rst_n && bus.grant_valid && bus.grant_ready) begin
        check_eq("hs_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("hs_grant", 32'(bus.grant), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [N-1:0] g;

    rst_n           = 1'b0;
    bus.req         = '0;
    bus.grant_ready = 1'b0;
    tick(3);
    mon_en = 1'b1;
    expect_out("reset", '0, 1'b0, 8'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("idle", '0, 1'b0, 8'd0);
    end

    // Single request with ready held high
    bus.req         = 16'h0040;
    bus.grant_ready = 1'b1;
    exp_q.push_back(16'h0040);
    tick();
    expect_out("s026_offer", 16'h0040, 1'b1, 8'd0);
    check_eq("s026_enc", 32'(enc(bus.grant)), 32'(4'b0110));
    bus.req = '0;
    tick();
    expect_out("s026_done", '0, 1'b0, 8'd1);
    bus.grant_ready = 1'b0;
    tick();
    expect_out("s026_bubble", '0, 1'b0, 8'd1);

    rst_n = 1'b0;
    tick();
    expect_out("rst2", '0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Two contending requesters, ready held
    bus.req         = 16'h8001;
    bus.grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = (RR && (i % 2 == 1)) ? 16'h8000 : 16'h0001;
      exp_q.push_back(g);
      tick();
      expect_out("s027_offer", g, 1'b1, 8'(i));
      tick();
      expect_out("s027_gap", '0, 1'b0, 8'(i + 1));
    end
    bus.req         = '0;
    bus.grant_ready = 1'b0;

    // Offer held while req changes and the granted bit drops
    bus.req = 16'h0004;
    exp_q.push_back(16'h0004);
    tick();
    expect_out("s028_offer", 16'h0004, 1'b1, 8'd4);
    bus.req = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("s028_hold", 16'h0004, 1'b1, 8'd4);
    end
    bus.grant_ready = 1'b1;
    exp_q.push_back(16'h0100);
    tick();
    expect_out("s028_accept", '0, 1'b0, 8'd5);
    bus.grant_ready = 1'b0;
    tick();
    expect_out("s028_next", 16'h0100, 1'b1, 8'd5);
    bus.grant_ready = 1'b1;
    tick();
    expect_out("s028_done", '0, 1'b0, 8'd6);

    // Ready in IDLE with no requests is ignored
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("idle_ready", '0, 1'b0, 8'd6);
    end
    bus.grant_ready = 1'b0;

    // Reset during OFFER beats a simultaneous ready
    bus.req = 16'h0010;
    tick();
    expect_out("s029_offer", 16'h0010, 1'b1, 8'd6);
    rst_n           = 1'b0;
    bus.grant_ready = 1'b1;
    tick();
    expect_out("s029_rst", '0, 1'b0, 8'd0);
    rst_n           = 1'b1;
    bus.grant_ready = 1'b0;
    bus.req         = 16'h8001;
    tick();
    expect_out("s029_ptr0", 16'h0001, 1'b1, 8'd0);
    exp_q.push_back(16'h0001);
    bus.grant_ready = 1'b1;
    tick();
    expect_out("s029_done", '0, 1'b0, 8'd1);

    // Counter wrap and index-15 pointer wrap
    bus.req = 16'hFFFF;
    for (int k = 0; k < 255; k++) begin
      g = RR ? (16'h0001 << ((1 + k) % 16)) : 16'h0001;
      exp_q.push_back(g);
      tick();
      check_eq("s030_grant", 32'(bus.grant), 32'(g));
      tick();
      check_eq("s030_cnt", 32'(bus.grant_cnt), 32'((2 + k) % 256));
    end
    check_eq("s030_wrap", 32'(bus.grant_cnt), 32'd0);
    exp_q.push_back(16'h0001);
    tick();
    check_eq("s030_ptr_wrap", 32'(bus.grant), 32'h0001);
    tick();
    check_eq("s030_cnt_after", 32'(bus.grant_cnt), 32'd1);
    bus.req         = '0;
    bus.grant_ready = 1'b0;
    tick(3);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
